bp_be_serial_sequencer: RTL and testbench

//  Sequences serializing instructions (fence, CSR, interrupt entry) at the BE issue stage.
//  - Drains the pipe, waits for memory credits to return, and grants exactly one dispatch slot.
//  - Then blocks younger instructions until the serializing op commits.
//  - Its stall output feeds the dispatch hazard logic as the control-hazard term for serial ops.

---
 rtl/bp_be_pkg.sv | 25 ++
 rtl/bp_be_serial_watchdog.sv | 28 ++
 rtl/bp_be_serial_sequencer.sv | 112 +++++++++++
 tb/tb_bp_be_serial_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the back-end serial sequencer: the serializing-instruction
// class carried from issue and the sequencer state encoding.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_serial_none  = 2'd0,
    e_serial_fence = 2'd1,
    e_serial_csr   = 2'd2,
    e_serial_irq   = 2'd3
  } bp_be_serial_class_e;

  typedef enum logic [2:0] {
    e_idle   = 3'd0,
    e_drain  = 3'd1,
    e_credit = 3'd2,
    e_issue  = 3'd3,
    e_commit = 3'd4
  } bp_be_serial_state_e;

  // A serializing op is present when the issue slot is valid and carries a class.
  function automatic logic is_serial_op(input logic v, input bp_be_serial_class_e c);
    return v & (c != e_serial_none);
  endfunction

endpackage

// File: rtl/bp_be_serial_watchdog.sv
// Saturating up-counter used to flag a drain that is taking suspiciously long.
// Clear wins over increment; the saturated flag is a level.
module bp_be_serial_watchdog #(
  parameter int width_p = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  logic [width_p-1:0] r_count;
  logic               w_sat;

  assign w_sat = &r_count;
  assign sat_o = w_sat;

  // Count while enabled, hold at all-ones, clear on reset or explicit clear.
  always_ff @(posedge clk_i) begin
    if (!reset_i || clr_i) begin
      r_count <= '0;
    end else if (inc_i && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/bp_be_serial_sequencer.sv
// Serial-op sequencer at the BE issue stage: drains the pipe (and memory
// credits for fences), grants a single dispatch slot, then holds younger
// instructions until the serializing op retires.
module bp_be_serial_sequencer
  import bp_be_pkg::*;
#(
  parameter int timeout_width_p = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       flush_i,
  input  logic       isd_v_i,
  input  logic [1:0] isd_serial_i,
  input  logic       instr_in_pipe_i,
  input  logic       mem_in_pipe_i,
  input  logic       credits_empty_i,
  input  logic       dispatch_ack_i,
  input  logic       commit_v_i,
  output logic       serial_stall_o,
  output logic       serial_grant_o,
  output logic [2:0] state_o,
  output logic       timeout_o
);

  bp_be_serial_state_e r_state, w_state_next;
  bp_be_serial_class_e r_class, w_class_next;
  bp_be_serial_class_e w_isd_class;
  logic w_new_serial;
  logic w_stall, w_grant;
  logic w_wd_inc, w_wd_clr;
  logic w_drained;

  assign w_isd_class  = bp_be_serial_class_e'(isd_serial_i);
  assign w_new_serial = is_serial_op(isd_v_i, w_isd_class);
  // Fences additionally need every memory op out of the pipe before leaving drain.
  assign w_drained    = ~instr_in_pipe_i & ~((r_class == e_serial_fence) & mem_in_pipe_i);

  // State and latched class registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= e_idle;
      r_class <= e_serial_none;
    end else begin
      r_state <= w_state_next;
      r_class <= w_class_next;
    end
  end

  // Next-state and output decode; flush overrides the next state only.
  always_comb begin
    w_state_next = r_state;
    w_class_next = r_class;
    w_stall      = 1'b0;
    w_grant      = 1'b0;
    w_wd_inc     = 1'b0;
    unique case (r_state)
      e_idle: begin
        w_stall = w_new_serial;
        if (w_new_serial) begin
          w_state_next = e_drain;
          w_class_next = w_isd_class;
        end
      end
      e_drain: begin
        w_stall  = 1'b1;
        w_wd_inc = 1'b1;
        if (w_drained) begin
          w_state_next = (r_class == e_serial_fence) ? e_credit : e_issue;
        end
      end
      e_credit: begin
        w_stall  = 1'b1;
        w_wd_inc = 1'b1;
        if (credits_empty_i) w_state_next = e_issue;
      end
      e_issue: begin
        w_grant = 1'b1;
        if (dispatch_ack_i) w_state_next = commit_v_i ? e_idle : e_commit;
      end
      e_commit: begin
        w_stall = 1'b1;
        if (commit_v_i) w_state_next = e_idle;
      end
      default: begin
        // Unreachable encodings recover to idle while holding dispatch off.
        w_stall      = 1'b1;
        w_state_next = e_idle;
      end
    endcase
    if (flush_i) begin
      w_state_next = e_idle;
      w_class_next = e_serial_none;
    end
  end

  assign w_wd_clr = flush_i | ((w_state_next == e_issue) & (r_state != e_issue));

  bp_be_serial_watchdog #(
    .width_p(timeout_width_p)
  ) u_watchdog (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (w_wd_clr),
    .inc_i  (w_wd_inc),
    .sat_o  (timeout_o)
  );

  assign serial_stall_o = w_stall;
  assign serial_grant_o = w_grant;
  assign state_o        = r_state;

endmodule

// File: tb/tb_bp_be_serial_sequencer.sv
// Self-checking bench for bp_be_serial_sequencer: per-cycle vector table with
// a scoreboard queue, plus a hand-written watchdog sequence.
module tb_bp_be_serial_sequencer;

  logic       clk = 1'b0;
  logic       reset_i, flush_i, isd_v_i;
  logic [1:0] isd_serial_i;
  logic       instr_in_pipe_i, mem_in_pipe_i, credits_empty_i;
  logic       dispatch_ack_i, commit_v_i;
  logic       serial_stall_o, serial_grant_o, timeout_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_be_serial_sequencer #(.timeout_width_p(3)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .isd_v_i        (isd_v_i),
    .isd_serial_i   (isd_serial_i),
    .instr_in_pipe_i(instr_in_pipe_i),
    .mem_in_pipe_i  (mem_in_pipe_i),
    .credits_empty_i(credits_empty_i),
    .dispatch_ack_i (dispatch_ack_i),
    .commit_v_i     (commit_v_i),
    .serial_stall_o (serial_stall_o),
    .serial_grant_o (serial_grant_o),
    .state_o        (state_o),
    .timeout_o      (timeout_o)
  );

  typedef struct {
    logic       chk;
    logic       rst_n, flush, v;
    logic [1:0] ser;
    logic       ip, mp, ce, ack, cm;
    logic       stall, grant;
    logic [2:0] st;
    logic       to;
  } vec_t;

  typedef struct {
    int         idx;
    logic       stall, grant;
    logic [2:0] st;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic chk, input logic rst_n, input logic flush,
                              input logic v, input logic [1:0] ser, input logic ip,
                              input logic mp, input logic ce, input logic ack,
                              input logic cm, input logic stall, input logic grant,
                              input logic [2:0] st, input logic to);
    vec_t t;
    t.chk = chk; t.rst_n = rst_n; t.flush = flush; t.v = v; t.ser = ser;
    t.ip = ip; t.mp = mp; t.ce = ce; t.ack = ack; t.cm = cm;
    t.stall = stall; t.grant = grant; t.st = st; t.to = to;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int idx, input logic [2:0] act,
                       input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t t);
    reset_i         = t.rst_n;
    flush_i         = t.flush;
    isd_v_i         = t.v;
    isd_serial_i    = t.ser;
    instr_in_pipe_i = t.ip;
    mem_in_pipe_i   = t.mp;
    credits_empty_i = t.ce;
    dispatch_ack_i  = t.ack;
    commit_v_i      = t.cm;
  endtask

  initial begin
    exp_t e;
    int   n_rise;

    reset_i = 1'b0; flush_i = 1'b0; isd_v_i = 1'b0; isd_serial_i = 2'd0;
    instr_in_pipe_i = 1'b0; mem_in_pipe_i = 1'b0; credits_empty_i = 1'b0;
    dispatch_ack_i = 1'b0; commit_v_i = 1'b0;

    //   chk rst fl v ser ip mp ce ak cm | stall grant st to
    // reset, then reset-state check
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // csr, empty pipe, ack at grant, commit three cycles later
    add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 1, 0,  0, 1, 3, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 4, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // fence: mem op keeps drain 4 cycles, credits 2 cycles, isd_v low meanwhile
    add(1, 1, 0, 1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 2, 0);
    add(1, 1, 0, 1, 1, 0, 0, 1, 0, 0,  0, 1, 3, 0);
    add(1, 1, 0, 1, 1, 0, 0, 1, 1, 1,  0, 1, 3, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // flush in e_credit
    add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // flush in e_commit
    add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 1, 0,  0, 1, 3, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 4, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // flush together with a new op in e_idle squashes it
    add(1, 1, 1, 1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // irq ignores mem_in_pipe, ack+commit together skip e_commit
    add(1, 1, 0, 1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 1, 3, 0, 1, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 1, 3, 0, 0, 0, 1, 1,  0, 1, 3, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // reset mid-drain, then a fresh csr restarts cleanly
    add(1, 1, 0, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 1, 0);
    add(1, 1, 0, 1, 2, 0, 0, 0, 1, 1,  0, 1, 3, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      if (vecs[i].chk) begin
        e.idx = i; e.stall = vecs[i].stall; e.grant = vecs[i].grant;
        e.st = vecs[i].st; e.to = vecs[i].to;
        sb.push_back(e);
      end
      @(negedge clk);
      if (vecs[i].chk) begin
        e = sb.pop_front();
        check("stall", e.idx, {2'b0, serial_stall_o}, {2'b0, e.stall});
        check("grant", e.idx, {2'b0, serial_grant_o}, {2'b0, e.grant});
        check("state", e.idx, state_o, e.st);
        check("timeout", e.idx, {2'b0, timeout_o}, {2'b0, e.to});
        $display("step %0d: stall=%0d grant=%0d state=%0d timeout=%0d",
                 e.idx, serial_stall_o, serial_grant_o, state_o, timeout_o);
      end
    end

    // Watchdog: csr with instr_in_pipe stuck high; 3-bit counter saturates at 7.
    @(posedge clk); #1;
    isd_v_i = 1'b1; isd_serial_i = 2'd2; instr_in_pipe_i = 1'b1;
    @(negedge clk);
    check("wd_idle_state", 100, state_o, 3'd0);
    @(posedge clk); #1;
    isd_v_i = 1'b0; isd_serial_i = 2'd0;
    n_rise = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeout_o === 1'b1) begin
        n_rise = k - 1;
        break;
      end
      @(posedge clk);
    end
    n_checks++;
    if (n_rise != 7) begin
      n_fail++;
      $display("FAIL wd_rise: drain cycles before timeout %0d expected 7", n_rise);
    end
    $display("watchdog: timeout after %0d drain cycles", n_rise);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check("wd_hold_timeout", 101 + k, {2'b0, timeout_o}, 3'd1);
      check("wd_hold_state", 101 + k, state_o, 3'd1);
    end
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("wd_flush_cycle_state", 104, state_o, 3'd1);
    @(posedge clk); #1;
    flush_i = 1'b0; instr_in_pipe_i = 1'b0;
    @(negedge clk);
    check("wd_after_flush_state", 105, state_o, 3'd0);
    check("wd_after_flush_timeout", 105, {2'b0, timeout_o}, 3'd0);
    check("wd_after_flush_stall", 105, {2'b0, serial_stall_o}, 3'd0);
    $display("watchdog: flushed, state=%0d timeout=%0d", state_o, timeout_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
